// File: rtl/body_pixel_tester.sv
// body_pixel_tester: per-pixel circle hit test against up to N_BODIES bodies.
// Physics writes body positions into shadow slots. frame_start copies them into
// the active slots, so a frame never tears. The result comes through a 3-stage
// pipeline, and the pixel coordinates are delayed to stay aligned with it.
// Optional feature: define BODY_OVERLAP_EN to add the overlap / overlap_seen outputs.
module body_pixel_tester #(
  parameter  int N_BODIES = 4,
  parameter  int RADIUS   = 4,
  parameter  int COORD_W  = 10,
  localparam int IW       = (N_BODIES > 1) ? $clog2(N_BODIES) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_idx,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic               wr_enable,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic               out_valid,
  output logic [COORD_W-1:0] out_DrawX,
  output logic [COORD_W-1:0] out_DrawY,
  output logic               is_ball,
  output logic [IW-1:0]      body_idx
`ifdef BODY_OVERLAP_EN
  ,
  output logic               overlap,
  output logic               overlap_seen
`endif
);

  localparam int STAGES = 3;
  localparam int DW     = COORD_W + 1;   // signed delta width
  localparam int SQW    = 2 * DW;        // one squared delta
  localparam int D2W    = 2 * DW + 1;    // sum of two squares, cannot overflow
  localparam logic [D2W-1:0] R2 = D2W'(RADIUS * RADIUS);

  // body slots
  logic [COORD_W-1:0]  r_sh_x [N_BODIES];
  logic [COORD_W-1:0]  r_sh_y [N_BODIES];
  logic [N_BODIES-1:0] r_sh_en;
  logic [COORD_W-1:0]  r_ac_x [N_BODIES];
  logic [COORD_W-1:0]  r_ac_y [N_BODIES];
  logic [N_BODIES-1:0] r_ac_en;

  // pipeline
  logic [STAGES:1]            r_vld_pipe;
  logic [COORD_W-1:0]         r_x_pipe [STAGES:1];
  logic [COORD_W-1:0]         r_y_pipe [STAGES:1];
  logic signed [DW-1:0]       r_dx [N_BODIES];
  logic signed [DW-1:0]       r_dy [N_BODIES];
  logic [N_BODIES-1:0]        r_en_s1;
  logic [N_BODIES-1:0]        r_hit;
  logic                       r_is_ball;
  logic [IW-1:0]              r_body_idx;

  logic signed [SQW-1:0] w_dx2 [N_BODIES];
  logic signed [SQW-1:0] w_dy2 [N_BODIES];
  logic [D2W-1:0]        w_d2  [N_BODIES];
  logic [N_BODIES-1:0]   w_hit;
  logic [N_BODIES-1:0]   w_hit_v;
  logic [IW-1:0]         w_idx;
  logic                  w_ovl;

  // Shadow writes and the frame swap. The swap copies the pre-edge shadow
  // value, so a write in the same cycle shows up only at the next swap.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sh_en <= '0;
      r_ac_en <= '0;
      for (int i = 0; i < N_BODIES; i++) begin
        r_sh_x[i] <= '0;
        r_sh_y[i] <= '0;
        r_ac_x[i] <= '0;
        r_ac_y[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BODIES; i++) begin
        if (wr_en && wr_idx == IW'(i)) begin
          r_sh_x[i]  <= wr_x;
          r_sh_y[i]  <= wr_y;
          r_sh_en[i] <= wr_enable;
        end
        if (frame_start) begin
          r_ac_x[i]  <= r_sh_x[i];
          r_ac_y[i]  <= r_sh_y[i];
          r_ac_en[i] <= r_sh_en[i];
        end
      end
    end
  end

  // S1: signed deltas against the active slots. Each pixel samples the
  // positions here, which makes a swap atomic for pixels already in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_en_s1 <= '0;
      for (int i = 0; i < N_BODIES; i++) begin
        r_dx[i] <= '0;
        r_dy[i] <= '0;
      end
    end else begin
      r_en_s1 <= r_ac_en;
      for (int i = 0; i < N_BODIES; i++) begin
        r_dx[i] <= $signed({1'b0, DrawX}) - $signed({1'b0, r_ac_x[i]});
        r_dy[i] <= $signed({1'b0, DrawY}) - $signed({1'b0, r_ac_y[i]});
      end
    end
  end

  // S2 comb: squared distance and hit compare (on-circle counts as a hit)
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_BODIES; i++) begin
      w_dx2[i] = r_dx[i] * r_dx[i];
      w_dy2[i] = r_dy[i] * r_dy[i];
      w_d2[i]  = {1'b0, w_dx2[i]} + {1'b0, w_dy2[i]};
      w_hit[i] = r_en_s1[i] && (w_d2[i] <= R2);
    end
  end

  // S2 register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_hit <= '0;
    else          r_hit <= w_hit;
  end

  // S3 comb: squash hits for invalid pixels, then pick the lowest hitting index
  always_comb begin
    w_hit_v = r_hit & {N_BODIES{r_vld_pipe[2]}};
    w_idx   = '0;
    for (int i = N_BODIES - 1; i >= 0; i--)
      if (w_hit_v[i]) w_idx = IW'(i);
    w_ovl   = |(w_hit_v & (w_hit_v - N_BODIES'(1)));
  end

  // S3 register plus the valid/coordinate delay line
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vld_pipe <= '0;
      r_is_ball  <= 1'b0;
      r_body_idx <= '0;
      for (int s = 1; s <= STAGES; s++) begin
        r_x_pipe[s] <= '0;
        r_y_pipe[s] <= '0;
      end
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], pix_valid};
      r_x_pipe[1] <= DrawX;
      r_y_pipe[1] <= DrawY;
      for (int s = 2; s <= STAGES; s++) begin
        r_x_pipe[s] <= r_x_pipe[s-1];
        r_y_pipe[s] <= r_y_pipe[s-1];
      end
      r_is_ball  <= |w_hit_v;
      r_body_idx <= w_idx;
    end
  end

  assign out_valid = r_vld_pipe[STAGES];
  assign out_DrawX = r_x_pipe[STAGES];
  assign out_DrawY = r_y_pipe[STAGES];
  assign is_ball   = r_is_ball;
  assign body_idx  = r_body_idx;

`ifdef BODY_OVERLAP_EN
  logic r_overlap;
  logic r_overlap_seen;

  // overlap is aligned with is_ball. The sticky flag is cleared by
  // frame_start, which beats a same-cycle set.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_overlap      <= 1'b0;
      r_overlap_seen <= 1'b0;
    end else begin
      r_overlap      <= w_ovl;
      r_overlap_seen <= frame_start ? 1'b0 : (r_overlap_seen | w_ovl);
    end
  end

  assign overlap      = r_overlap;
  assign overlap_seen = r_overlap_seen;
`else
  logic w_unused;
  assign w_unused = w_ovl;
`endif

endmodule

// File: tb/tb_body_pixel_tester.sv
// Scoreboard bench for body_pixel_tester. The expected result is computed from
// a behavioural slot model when each pixel is driven, and checked 3 cycles later.
module tb_body_pixel_tester;
  localparam int NB = 4;
  localparam int R  = 4;
  localparam int CW = 10;
  localparam int IW = 2;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          frame_start, wr_en, wr_enable, pix_valid;
  logic [IW-1:0] wr_idx;
  logic [CW-1:0] wr_x, wr_y, DrawX, DrawY;
  logic          out_valid, is_ball;
  logic [CW-1:0] out_DrawX, out_DrawY;
  logic [IW-1:0] body_idx;
`ifdef BODY_OVERLAP_EN
  logic          overlap, overlap_seen;
  logic          exp_seen = 1'b0;
`endif

  body_pixel_tester #(.N_BODIES(NB), .RADIUS(R), .COORD_W(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
    .wr_enable(wr_enable), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
    .out_valid(out_valid), .out_DrawX(out_DrawX), .out_DrawY(out_DrawY),
    .is_ball(is_ball), .body_idx(body_idx)
`ifdef BODY_OVERLAP_EN
    , .overlap(overlap), .overlap_seen(overlap_seen)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic v;
    int   x, y;
    logic ball;
    int   idx;
    logic ovl;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  int   m_sh_x [NB], m_sh_y [NB], m_ac_x [NB], m_ac_y [NB];
  bit   m_sh_en[NB], m_ac_en[NB];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic v, input int x, input int y);
    exp_t e;
    int   n;
    e.v = v; e.x = x; e.y = y; e.ball = 1'b0; e.idx = 0; e.ovl = 1'b0;
    n = 0;
    for (int i = 0; i < NB; i++) begin
      int dx, dy;
      dx = x - m_ac_x[i];
      dy = y - m_ac_y[i];
      if (m_ac_en[i] && (dx * dx + dy * dy <= R * R)) begin
        if (n == 0) e.idx = i;
        n++;
      end
    end
    if (v) begin
      e.ball = (n > 0);
      e.ovl  = (n >= 2);
    end else begin
      e.idx = 0;
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_sh_x[i] = 0; m_sh_y[i] = 0; m_sh_en[i] = 0;
      m_ac_x[i] = 0; m_ac_y[i] = 0; m_ac_en[i] = 0;
    end
  endtask

  // One cycle: check the output produced by the pixel driven 3 steps ago,
  // then drive this cycle's inputs and push their expected result.
  task automatic step(input logic v, input int x, input int y,
                      input logic fs = 1'b0, input logic we = 1'b0, input int wi = 0,
                      input int wx = 0, input int wy = 0, input logic wen = 1'b0);
    exp_t e;
    logic popped_ovl;
    @(negedge Clk);
    popped_ovl = 1'b0;
    if (sbq.size() >= 3) begin
      e = sbq.pop_front();
      chk("out_valid", out_valid, e.v);
      if (e.v) begin
        chk("out_DrawX", out_DrawX, e.x);
        chk("out_DrawY", out_DrawY, e.y);
      end
      chk("is_ball", is_ball, e.ball);
      chk("body_idx", body_idx, e.idx);
`ifdef BODY_OVERLAP_EN
      chk("overlap", overlap, e.ovl);
`endif
      popped_ovl = e.ovl;
    end
`ifdef BODY_OVERLAP_EN
    exp_seen = frame_start ? 1'b0 : (exp_seen | popped_ovl);
    chk("overlap_seen", overlap_seen, exp_seen);
`endif
    sbq.push_back(model(v, x, y));
    pix_valid = v; DrawX = CW'(x); DrawY = CW'(y);
    frame_start = fs;
    wr_en = we; wr_idx = IW'(wi); wr_x = CW'(wx); wr_y = CW'(wy); wr_enable = wen;
    if (fs) begin
      for (int i = 0; i < NB; i++) begin
        m_ac_x[i] = m_sh_x[i]; m_ac_y[i] = m_sh_y[i]; m_ac_en[i] = m_sh_en[i];
      end
    end
    if (we) begin
      m_sh_x[wi] = wx; m_sh_y[wi] = wy; m_sh_en[wi] = wen;
    end
  endtask

  task automatic wr(input int i, input int x, input int y, input logic en);
    step(1'b0, 0, 0, 1'b0, 1'b1, i, x, y, en);
  endtask

  task automatic swap();
    step(1'b0, 0, 0, 1'b1);
  endtask

  task automatic pix(input int x, input int y);
    step(1'b1, x, y);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_ball"},  is_ball, 0);
    chk({tag, "_idx"},   body_idx, 0);
    chk({tag, "_x"},     out_DrawX, 0);
    chk({tag, "_y"},     out_DrawY, 0);
`ifdef BODY_OVERLAP_EN
    chk({tag, "_ovl"},   overlap, 0);
    chk({tag, "_seen"},  overlap_seen, 0);
`endif
  endtask

  initial begin
    Reset_n = 1'b0;
    frame_start = 0; wr_en = 0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_enable = 0;
    pix_valid = 0; DrawX = '0; DrawY = '0;
    model_reset();
    #1;
    check_zero_outputs("reset");
    @(negedge Clk); @(negedge Clk);
    Reset_n = 1'b1;

    // empty frame: nothing hits, out_valid follows pix_valid by 3 cycles
    swap();
    for (int y = 0; y < 480; y += 37)
      for (int x = 0; x < 640; x += 7)
        step($urandom_range(0, 3) != 0, x, y);
    pix(639, 479);

    // single body, on-circle edge and just outside
    wr(1, 100, 50, 1'b1);
    swap();
    pix(104, 50); pix(105, 50); pix(103, 53); pix(96, 50); pix(100, 46);
    pix(100, 50); pix(97, 47);

    // shadow write is invisible until the swap
    wr(0, 200, 200, 1'b1);
    pix(200, 200);
    swap();
    pix(200, 200); pix(201, 203);

    // write in the same cycle as frame_start lands one frame later
    step(1'b1, 10, 10, 1'b1, 1'b1, 2, 10, 10, 1'b1);
    pix(10, 10);
    swap();
    pix(10, 10);

    // two bodies on the same spot: lowest index wins, overlap is flagged
    wr(0, 300, 300, 1'b1);
    wr(3, 300, 300, 1'b1);
    swap();
    pix(300, 300); pix(302, 301);
    idle(4);
    swap();
    idle(3);
    // overlap reaching S3 in the same cycle as frame_start: the clear wins
    pix(300, 300);
    idle(1);
    swap();
    idle(4);

    // body near the origin, negative deltas
    wr(3, 0, 0, 1'b1);
    wr(0, 5, 5, 1'b1);
    swap();
    pix(0, 0); pix(2, 2); pix(3, 3); pix(1, 5); pix(6, 10); pix(7, 7); pix(9, 5);

    // random pixels around the active bodies
    for (int k = 0; k < 200; k++) begin
      int b;
      b = $urandom_range(0, 3);
      step($urandom_range(0, 4) != 0,
           m_ac_x[b] + $urandom_range(0, 12) - (m_ac_x[b] >= 6 ? 6 : 0),
           m_ac_y[b] + $urandom_range(0, 12) - (m_ac_y[b] >= 6 ? 6 : 0));
    end

    // all bodies disabled
    for (int i = 0; i < NB; i++) wr(i, m_sh_x[i], m_sh_y[i], 1'b0);
    swap();
    pix(0, 0); pix(5, 5); pix(10, 10); pix(100, 50);

    // reset while a hit is in flight
    wr(1, 100, 50, 1'b1);
    swap();
    pix(100, 50); pix(101, 50);
    #2;
    Reset_n = 1'b0;
    pix_valid = 0; frame_start = 0; wr_en = 0;
    #1;
    check_zero_outputs("midrst");
    sbq.delete();
    model_reset();
`ifdef BODY_OVERLAP_EN
    exp_seen = 1'b0;
`endif
    @(negedge Clk); @(negedge Clk);
    Reset_n = 1'b1;
    pix(100, 50);
    swap();
    pix(100, 50);
    wr(1, 100, 50, 1'b1);
    swap();
    pix(100, 50); pix(100, 54);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/body_pixel_tester.md
Name: body_pixel_tester

Overview:
- Per-pixel hit-test stage directly upstream of the colour mapper; produces its is_ball input.
- Holds positions for up to N_BODIES gravity bodies and tests each scanned pixel (DrawX, DrawY) against a square-distance circle of radius RADIUS.
- Body positions are written by the physics side into shadow registers and become visible atomically at frame_start, so no frame tears.
- Output is pipelined, with delayed coordinates kept aligned for the colour mapper.

Parameters:
- N_BODIES, 4, number of bodies; index width IW = max(1, clog2(N_BODIES)).
- RADIUS, 4, body radius in pixels; hit when dx*dx + dy*dy <= RADIUS*RADIUS.
- COORD_W, 10, pixel coordinate width.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank; shadow registers are copied to active registers.
- wr_en  in  1  write one body slot into shadow registers.
- wr_idx  in  IW  slot index; writes with wr_idx >= N_BODIES are ignored.
- wr_x  in  COORD_W  body centre X.
- wr_y  in  COORD_W  body centre Y.
- wr_enable  in  1  1 = body drawn, 0 = slot disabled.
- pix_valid  in  1  DrawX/DrawY qualify a visible pixel this cycle.
- DrawX  in  COORD_W  current pixel X.
- DrawY  in  COORD_W  current pixel Y.
- out_valid  out  1  delayed pix_valid.
- out_DrawX  out  COORD_W  DrawX delayed to align with is_ball.
- out_DrawY  out  COORD_W  DrawY delayed to align with is_ball.
- is_ball  out  1  pixel lies inside at least one enabled body.
- body_idx  out  IW  lowest index of hitting body; 0 when is_ball = 0.

Behaviour:
- Reset (async assert, sync deassert use): all shadow/active x, y, enable = 0; pipeline valids = 0; all outputs = 0.
- Shadow write: on wr_en with valid wr_idx, shadow[wr_idx] <= {wr_x, wr_y, wr_enable} next edge. Repeated writes to one slot before frame_start: last write wins.
- Swap: on frame_start, active[i] <= shadow[i] for all i, using the shadow value held *before* the edge.
  - wr_en and frame_start in the same cycle: the write lands in shadow only and becomes active at the next frame_start.
- Pipeline: fixed 3-cycle latency, one pixel per cycle, no stalls. pix_valid at cycle t gives out_valid at t+3, with coordinates and result aligned.
  - S1: register dx = DrawX - x_i and dy = DrawY - y_i as signed COORD_W+1 values for every body, using the active registers at this edge. Also register enable_i, valid and coordinates.
  - S2: d2_i = dx*dx + dy*dy, unsigned 2*(COORD_W+1)+1 bits, no overflow possible. hit_i = enable_i && d2_i <= RADIUS*RADIUS. Register.
  - S3: is_ball = OR(hit_i); body_idx = lowest i with hit_i, else 0. Register outputs.
- Pixels already in flight at a swap keep the positions sampled in S1; the swap never splits one pixel's test.
- When pix_valid = 0: the pipeline still advances; is_ball is forced 0 and body_idx 0 at the output.
- Boundaries:
  - Body at (0,0) wraps nowhere; negative dx/dy are handled by signed arithmetic.
  - d2 exactly equal to RADIUS² is a hit.
  - All bodies disabled gives is_ball = 0.

Optional Feature:
- Macro BODY_OVERLAP_EN.
- Defined: adds outputs overlap (1 bit, aligned with is_ball) and overlap_seen (1 bit).
  - overlap = 1 when two or more hit_i are set for a valid pixel.
  - overlap_seen is sticky: set on any overlap, cleared on frame_start (frame_start wins over a same-cycle set), reset 0.
  - Physics uses it as a coarse collision hint.
- Undefined: ports absent, no extra logic.

Test Plan:
- Reset then frame_start with no writes; sweep pixels (0..639, 0..479) -> is_ball = 0 and out_valid tracks pix_valid with exactly 3-cycle latency.
- Write slot 1 = (100, 50, enabled), frame_start, drive (104, 50) -> 3 cycles later is_ball = 1, body_idx = 1. Drive (105, 50) -> is_ball = 0. Drive (103, 53), where d2 = 18 > 16 -> 0.
- Write slot 0 = (200, 200) without frame_start; drive (200, 200) -> is_ball = 0. Pulse frame_start, drive again -> is_ball = 1, body_idx = 0.
- wr_en on slot 2 = (10, 10) in the same cycle as frame_start; drive (10, 10) -> 0 this frame, 1 after the next frame_start.
- Slots 0 and 3 both at (300, 300), enabled; drive (300, 300) -> is_ball = 1, body_idx = 0. With BODY_OVERLAP_EN: overlap = 1, overlap_seen stays 1 until the next frame_start.
- Assert Reset_n low mid-sweep with a body active -> outputs 0 immediately; active slots are cleared, so is_ball = 0 after release until new writes and a frame_start.
